det_share_ctrl: RTL

DET_SHARE_CTRL -- requirements
Module: det_share_ctrl

---
 rtl/det_pkg.sv | 20 ++
 rtl/det_share_ctrl_if.sv | 34 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/det_share_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/det_pkg.sv
// Shared definitions for the shared-channel sequence detector.
//   PAT_LEN     : length of the detected serial pattern
//   DEF_PATTERN : default pattern, MSB is the first bit on the wire
//   state_e     : controller FSM encoding
//   id_width    : width of a requester index for n requesters (min 1)
package det_pkg;
    localparam int PAT_LEN = 7;
    localparam logic [PAT_LEN-1:0] DEF_PATTERN = 7'b1010011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_RUN    = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/det_share_ctrl_if.sv
// Requester-side bundle of det_share_ctrl.
//   req/data_in/data_valid : per-requester request, serial bit and qualifier
//   gnt                    : one-hot grant
//   busy/done/abort        : controller status and completion pulses
//   done_id/match_cnt      : result of the last finished or aborted frame
// master = requester side, slave = controller side.
interface det_share_ctrl_if
    import det_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 5
);
    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] data_in;
    logic [NUM_REQ-1:0] data_valid;
    logic [NUM_REQ-1:0] gnt;
    logic               busy;
    logic               done;
    logic               abort;
    logic [ID_W-1:0]    done_id;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output req, data_in, data_valid,
        input  gnt, busy, done, abort, done_id, match_cnt
    );

    modport slave (
        input  req, data_in, data_valid,
        output gnt, busy, done, abort, done_id, match_cnt
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : index with highest priority this round
//   en  : arbitration enable; gnt is zero when low
//   gnt : one-hot grant (zero when no request or not enabled)
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt
);
    logic            found;
    logic [ID_W-1:0] idx;

    // Scan from ptr upward with wrap; first active request wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/det_share_ctrl.sv
// Shared serial pattern detector: arbitrates one of NUM_REQ requesters,
// counts (overlapping) occurrences of PATTERN in FRAME_LEN valid bits of
// that requester's stream, and reports the count with done, or with abort
// if the requester drops req mid-frame.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : det_share_ctrl_if slave port (req/data in, gnt/status out)
// Bits presented while in CLEAR (first gnt cycle) are ignored; the first
// accepted bit is in the cycle after gnt first rises.
module det_share_ctrl
    import det_pkg::*;
#(
    parameter int                  NUM_REQ   = 4,
    parameter logic [PAT_LEN-1:0]  PATTERN   = DEF_PATTERN,
    parameter int                  FRAME_LEN = 16,
    parameter int                  CNT_W     = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    det_share_ctrl_if.slave bus
);
    localparam int ID_W   = id_width(NUM_REQ);
    localparam int BC_W   = $clog2(FRAME_LEN + 1);
    localparam int FILL_W = $clog2(PAT_LEN + 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, arb_gnt;
    logic [ID_W-1:0]      gidx_q, arb_idx, rr_ptr_q;
    logic                 arb_any;

    logic [PAT_LEN-1:0]   shift_q, shift_nxt;
    logic [FILL_W-1:0]    fill_q, fill_nxt;
    logic [BC_W-1:0]      bit_cnt_q;
    logic [CNT_W-1:0]     mcnt_q, mcnt_nxt;

    logic                 abort_q;
    logic [ID_W-1:0]      done_id_q;
    logic [CNT_W-1:0]     mcnt_out_q;

    logic                 in_frame, cur_req, cur_bit, cur_vld;
    logic                 req_drop, bit_acc, match, last_bit;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req (bus.req),
        .ptr (rr_ptr_q),
        .en  (state_q == ST_IDLE),
        .gnt (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (arb_gnt[i]) arb_idx = ID_W'(i);
    end
    assign arb_any = |arb_gnt;

    // Only the granted lane is looked at.
    assign in_frame = (state_q == ST_CLEAR) || (state_q == ST_RUN);
    assign cur_req  = bus.req[gidx_q];
    assign cur_bit  = bus.data_in[gidx_q];
    assign cur_vld  = bus.data_valid[gidx_q];

    // Abort wins over a coincident valid bit.
    assign req_drop = in_frame && !cur_req;
    assign bit_acc  = (state_q == ST_RUN) && cur_req && cur_vld;

    assign shift_nxt = {shift_q[PAT_LEN-2:0], cur_bit};
    assign fill_nxt  = (fill_q == FILL_W'(PAT_LEN)) ? fill_q : fill_q + 1'b1;
    // Compare includes the incoming bit; fill guards against matching on
    // the zeros left by CLEAR.
    assign match     = bit_acc && (shift_nxt == PATTERN) && (fill_nxt == FILL_W'(PAT_LEN));
    assign mcnt_nxt  = (match && (mcnt_q != {CNT_W{1'b1}})) ? mcnt_q + 1'b1 : mcnt_q;
    assign last_bit  = bit_acc && (bit_cnt_q == BC_W'(FRAME_LEN - 1));

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (arb_any) state_d = ST_CLEAR;
            ST_CLEAR:  state_d = req_drop ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                if (req_drop)      state_d = ST_IDLE;
                else if (last_bit) state_d = ST_REPORT;
            end
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.busy = in_frame;
        bus.done = (state_q == ST_REPORT);
        bus.gnt  = in_frame ? gnt_q : '0;
    end

    assign bus.abort     = abort_q;
    assign bus.done_id   = done_id_q;
    assign bus.match_cnt = mcnt_out_q;

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_q      <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            shift_q    <= '0;
            fill_q     <= '0;
            bit_cnt_q  <= '0;
            mcnt_q     <= '0;
            abort_q    <= 1'b0;
            done_id_q  <= '0;
            mcnt_out_q <= '0;
        end else begin
            abort_q <= req_drop;

            if (state_q == ST_IDLE && arb_any) begin
                gnt_q    <= arb_gnt;
                gidx_q   <= arb_idx;
                rr_ptr_q <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            end

            if (state_q == ST_CLEAR) begin
                shift_q   <= '0;
                fill_q    <= '0;
                bit_cnt_q <= '0;
                mcnt_q    <= '0;
            end else if (bit_acc) begin
                shift_q   <= shift_nxt;
                fill_q    <= fill_nxt;
                bit_cnt_q <= bit_cnt_q + 1'b1;
                mcnt_q    <= mcnt_nxt;
            end

            // mcnt_q still holds the previous frame while in CLEAR.
            if (req_drop) begin
                done_id_q  <= gidx_q;
                mcnt_out_q <= (state_q == ST_CLEAR) ? '0 : mcnt_q;
            end else if (last_bit) begin
                done_id_q  <= gidx_q;
                mcnt_out_q <= mcnt_nxt;
            end
        end
    end
endmodule
